clint_mh: RTL and testbench
===========================

Name: clint_mh

Overview:
- Parametrised multi-hart core-local interruptor. Successor to the single-hart CLINT.
- Provides one shared 64-bit mtime, and per-hart msip and 64-bit mtimecmp.
- Adds features the single-hart block lacks:
  - writable mtime;
  - programmable RTC prescaler and count enable;
  - tear-free 64-bit mtime reads through a shadow high word;
  - bus error on unmapped addresses.
- Sits on the APB4 peripheral bus and drives one timer IRQ and one software IRQ per hart.

Parameters:
HART_NUM, 4, number of harts (1..16); sizes msip, mtimecmp and IRQ vectors
PSC_WIDTH, 8, width of RTC prescaler field in CTRL (1..16)
ADDR_WIDTH, 12, APB address bits decoded

Ports:
clk_i  in  1  bus/system clock; all logic on its rising edge
rst_n_i  in  1  async active-low reset
rtc_clk_i  in  1  slow RTC clock, asynchronous; sampled as data, never used as a clock
paddr_i  in  ADDR_WIDTH  APB address (bits 1:0 ignored)
psel_i  in  1  APB select
penable_i  in  1  APB enable
pwrite_i  in  1  APB write
pwdata_i  in  32  APB write data
pstrb_i  in  4  APB byte strobes
prdata_o  out  32  APB read data
pready_o  out  1  always 1 (zero wait state)
pslverr_o  out  1  error on unmapped access
tmr_irq_o  out  HART_NUM  machine timer interrupt per hart
sfr_irq_o  out  HART_NUM  machine software interrupt per hart

Behaviour:
- One clock domain (clk_i); reset is asynchronous, active-low on rst_n_i.
- Register map (byte offsets):
  - MSIP[h]: 0x000+4h, bit0 RW, bits 31:1 read 0.
  - MTIMECMPL[h]: 0x100+8h, RW. MTIMECMPH[h]: 0x104+8h, RW.
  - MTIMEL: 0x200, RW. MTIMEH: 0x204, RW.
  - CTRL: 0x208. Bit0 EN (RW), bits PSC_WIDTH+7:8 PSC (RW), other bits read 0.
- APB access:
  - Write commits in the access phase (psel_i & penable_i & pwrite_i).
  - Bytes are masked by pstrb_i.
  - prdata_o is combinational from the address during the access phase and 0 otherwise.
- Unmapped address, including hart index >= HART_NUM:
  - pslverr_o=1 in the access phase.
  - Write is ignored; read returns 0.
- Reset values:
  - msip=0; mtimecmp[h]=64'hFFFF_FFFF_FFFF_FFFF; mtime=0; shadow=0.
  - EN=1; PSC=0; prescaler count=0; sync flops=0.
  - tmr_irq_o=0; sfr_irq_o=0; prdata_o=0; pslverr_o=0.
- RTC tick:
  - rtc_clk_i passes through a 2-flop synchroniser, then a third flop.
  - rtc_rise = synced & ~delayed, one clk_i-cycle pulse.
  - On rtc_rise with EN=1: if prescaler count == PSC, count<=0 and mtime increments; else count increments.
  - Result: mtime advances once per PSC+1 RTC rising edges. With PSC=0 that is every RTC edge.
  - EN=0 freezes mtime and the prescaler count.
  - A write to CTRL clears the prescaler count.
- mtime arithmetic: 64-bit unsigned; 64'hFFFF_FFFF_FFFF_FFFF + 1 wraps to 0.
- Write to MTIMEL/MTIMEH:
  - Replaces that 32-bit half only (bytes per pstrb_i).
  - Takes priority over an increment in the same cycle; that increment is lost.
  - No carry into the other half.
- Tear-free read:
  - Reading MTIMEL returns mtime[31:0] and loads shadow<=mtime[63:32] in the same cycle.
  - Reading MTIMEH returns shadow.
  - Software reads L then H.
  - Writing MTIMEH also updates shadow.
- IRQ outputs:
  - tmr_irq_o[h] is registered: tmr_irq_o[h] <= (mtime >= mtimecmp[h]), unsigned 64-bit compare using the current-cycle register values.
  - Latency is 1 clk_i after any mtime or mtimecmp change. The level holds while the condition holds.
  - sfr_irq_o[h] is the msip[h] flop directly, visible the cycle after the write.
- Boundaries:
  - Writing one mtimecmp half can transiently assert the IRQ; software writes H=all-ones first.
  - Mid-operation reset clears everything asynchronously; outputs drop immediately.

Test Plan:
- Reset, then read every register: MSIP=0, MTIMECMP=0xFFFFFFFF, MTIME=0, CTRL=0x1, pslverr_o=0. tmr_irq_o=0 and sfr_irq_o=0.
- Write MSIP[2]=1 (HART_NUM=4): sfr_irq_o=4'b0100 one cycle later. Write 0: cleared. Read 0x008 returns 1 while set.
- PSC=3, EN=1, 12 RTC edges: MTIMEL=3. With EN=0 and 5 further edges: MTIMEL still 3.
- MTIMECMP[0]=0x10, MTIMECMP[1]=0x20, 0x10 ticks: tmr_irq_o=2'b01 exactly 1 clk after mtime=0x10. Raising MTIMECMP[0] to 0x100 deasserts the IRQ 1 clk later.
- Wrap and tear-free read:
  - Write MTIMEL=0xFFFFFFFF and MTIMEH=0xFFFFFFFF, then 1 tick: mtime=0.
  - With MTIMEL=0xFFFFFFFF, read L, tick, read H: returns the pre-tick high word.
- Access 0x130 (hart 6) and 0x300: pslverr_o=1 and prdata_o=0; no register changes. A write to MTIMEL on the same cycle as rtc_rise keeps the written value.

Source files
------------

// File: rtl/clint_mh.sv
// clint_mh: multi-hart core-local interruptor on APB4. It holds one shared mtime,
// and per-hart msip and mtimecmp. It adds a prescaled RTC tick and tear-free mtime reads.
module clint_mh #(
  parameter int HART_NUM   = 4,
  parameter int PSC_WIDTH  = 8,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  rtc_clk_i,
  input  logic [ADDR_WIDTH-1:0] paddr_i,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [31:0]           pwdata_i,
  input  logic [3:0]            pstrb_i,
  output logic [31:0]           prdata_o,
  output logic                  pready_o,
  output logic                  pslverr_o,
  output logic [HART_NUM-1:0]   tmr_irq_o,
  output logic [HART_NUM-1:0]   sfr_irq_o
);

  function automatic logic [31:0] f_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

  logic [HART_NUM-1:0]  r_msip;
  logic [63:0]          r_mtimecmp [HART_NUM];
  logic [63:0]          r_mtime;
  logic [31:0]          r_shadow;
  logic                 r_en;
  logic [PSC_WIDTH-1:0] r_psc;
  logic [PSC_WIDTH-1:0] r_psc_cnt;
  logic [1:0]           r_rtc_sync;
  logic                 r_rtc_dly;
  logic [HART_NUM-1:0]  r_tmr_irq;

  logic [31:0]          w_off;
  logic                 w_access;
  logic                 w_hit;
  logic                 w_wr;
  logic                 w_rd;
  logic                 w_msip_rgn;
  logic                 w_cmp_rgn;
  logic [3:0]           w_idx_m;
  logic [3:0]           w_idx_c;
  logic                 w_cmp_hi;
  logic [HART_NUM-1:0]  w_sel_m;
  logic [HART_NUM-1:0]  w_sel_c;
  logic [31:0]          w_hart_rdata;
  logic                 w_glb_hit;
  logic [31:0]          w_glb_rdata;
  logic [31:0]          w_ctrl;
  logic [31:0]          w_ctrl_wr;
  logic                 w_wr_ml;
  logic                 w_wr_mh;
  logic                 w_wr_ctl;
  logic                 w_rd_ml;
  logic                 w_rtc_rise;
  logic                 w_tick;
  logic [63:0]          w_mtime_nxt;

  assign w_off      = 32'(paddr_i) & 32'hFFFF_FFFC;
  assign w_access   = psel_i & penable_i;
  assign w_msip_rgn = (w_off[31:6] == 26'd0);
  assign w_cmp_rgn  = (w_off[31:7] == 25'd2);
  assign w_idx_m    = w_off[5:2];
  assign w_idx_c    = w_off[6:3];
  assign w_cmp_hi   = w_off[2];

  // Per-hart decode and read data (hart indices beyond HART_NUM never select)
  always_comb begin
    w_sel_m      = {HART_NUM{1'b0}};
    w_sel_c      = {HART_NUM{1'b0}};
    w_hart_rdata = 32'd0;
    for (int h = 0; h < HART_NUM; h++) begin
      w_sel_m[h]   = w_msip_rgn & (w_idx_m == 4'(h));
      w_sel_c[h]   = w_cmp_rgn & (w_idx_c == 4'(h));
      w_hart_rdata = w_hart_rdata
                   | ({32{w_sel_m[h]}} & {31'd0, r_msip[h]})
                   | ({32{w_sel_c[h]}} & (w_cmp_hi ? r_mtimecmp[h][63:32] : r_mtimecmp[h][31:0]));
    end
  end

  // CTRL image as seen on the bus
  always_comb begin
    w_ctrl                 = 32'd0;
    w_ctrl[0]              = r_en;
    w_ctrl[PSC_WIDTH+7:8]  = r_psc;
  end

  // Shared timer/control register decode
  always_comb begin
    w_glb_hit   = 1'b1;
    w_glb_rdata = 32'd0;
    case (w_off)
      32'h0000_0200: w_glb_rdata = r_mtime[31:0];
      32'h0000_0204: w_glb_rdata = r_shadow;
      32'h0000_0208: w_glb_rdata = w_ctrl;
      default:       w_glb_hit   = 1'b0;
    endcase
  end

  assign w_hit     = (|w_sel_m) | (|w_sel_c) | w_glb_hit;
  assign w_wr      = w_access & pwrite_i & w_hit;
  assign w_rd      = w_access & ~pwrite_i & w_hit;
  assign w_wr_ml   = w_wr & (w_off == 32'h0000_0200);
  assign w_wr_mh   = w_wr & (w_off == 32'h0000_0204);
  assign w_wr_ctl  = w_wr & (w_off == 32'h0000_0208);
  assign w_rd_ml   = w_rd & (w_off == 32'h0000_0200);
  assign w_ctrl_wr = f_merge(w_ctrl, pwdata_i, pstrb_i);

  assign prdata_o  = w_access ? (w_hart_rdata | w_glb_rdata) : 32'd0;
  assign pslverr_o = w_access & ~w_hit;
  assign pready_o  = 1'b1;

  // RTC synchroniser plus one delay flop for rising-edge detection
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rtc_sync <= 2'b00;
      r_rtc_dly  <= 1'b0;
    end else begin
      r_rtc_sync <= {r_rtc_sync[0], rtc_clk_i};
      r_rtc_dly  <= r_rtc_sync[1];
    end
  end

  assign w_rtc_rise = r_rtc_sync[1] & ~r_rtc_dly;
  assign w_tick     = w_rtc_rise & r_en & (r_psc_cnt == r_psc);

  // CTRL fields and prescaler count; a CTRL write restarts the prescaler
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_en      <= 1'b1;
      r_psc     <= {PSC_WIDTH{1'b0}};
      r_psc_cnt <= {PSC_WIDTH{1'b0}};
    end else if (w_wr_ctl) begin
      r_en      <= w_ctrl_wr[0];
      r_psc     <= w_ctrl_wr[PSC_WIDTH+7:8];
      r_psc_cnt <= {PSC_WIDTH{1'b0}};
    end else if (w_rtc_rise && r_en) begin
      r_psc_cnt <= w_tick ? {PSC_WIDTH{1'b0}} : r_psc_cnt + PSC_WIDTH'(1);
    end
  end

  // A bus write to either mtime half wins over a same-cycle tick, with no carry across halves
  always_comb begin
    if (w_wr_ml) begin
      w_mtime_nxt = {r_mtime[63:32], f_merge(r_mtime[31:0], pwdata_i, pstrb_i)};
    end else if (w_wr_mh) begin
      w_mtime_nxt = {f_merge(r_mtime[63:32], pwdata_i, pstrb_i), r_mtime[31:0]};
    end else begin
      w_mtime_nxt = r_mtime + {63'd0, w_tick};
    end
  end

  // mtime and the high-word shadow captured by an MTIMEL read
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_mtime  <= 64'd0;
      r_shadow <= 32'd0;
    end else begin
      r_mtime <= w_mtime_nxt;
      if (w_wr_mh) begin
        r_shadow <= w_mtime_nxt[63:32];
      end else if (w_rd_ml) begin
        r_shadow <= r_mtime[63:32];
      end
    end
  end

  // Per-hart msip and mtimecmp registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_msip <= {HART_NUM{1'b0}};
      for (int h = 0; h < HART_NUM; h++) begin
        r_mtimecmp[h] <= 64'hFFFF_FFFF_FFFF_FFFF;
      end
    end else begin
      for (int h = 0; h < HART_NUM; h++) begin
        if (w_wr && w_sel_m[h] && pstrb_i[0]) begin
          r_msip[h] <= pwdata_i[0];
        end
        if (w_wr && w_sel_c[h]) begin
          if (w_cmp_hi) begin
            r_mtimecmp[h][63:32] <= f_merge(r_mtimecmp[h][63:32], pwdata_i, pstrb_i);
          end else begin
            r_mtimecmp[h][31:0] <= f_merge(r_mtimecmp[h][31:0], pwdata_i, pstrb_i);
          end
        end
      end
    end
  end

  // Timer interrupts, one cycle behind the compared registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_tmr_irq <= {HART_NUM{1'b0}};
    end else begin
      for (int h = 0; h < HART_NUM; h++) begin
        r_tmr_irq[h] <= (r_mtime >= r_mtimecmp[h]);
      end
    end
  end

  assign tmr_irq_o = r_tmr_irq;
  assign sfr_irq_o = r_msip;

endmodule

// File: tb/tb_clint_mh.sv
// Testbench for clint_mh: directed register-map scenarios plus randomized APB/RTC traffic
// checked against a transaction-level register model.
module tb_clint_mh;
  localparam int HN = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rtc;
  logic [11:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic [HN-1:0] tmr_irq;
  logic [HN-1:0] sfr_irq;

  clint_mh #(.HART_NUM(HN), .PSC_WIDTH(8), .ADDR_WIDTH(12)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .rtc_clk_i(rtc),
    .paddr_i(paddr), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
    .pwdata_i(pwdata), .pstrb_i(pstrb), .prdata_o(prdata), .pready_o(pready),
    .pslverr_o(pslverr), .tmr_irq_o(tmr_irq), .sfr_irq_o(sfr_irq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Register model: the architectural state the map exposes
  logic [HN-1:0] m_msip;
  logic [63:0]   m_cmp [HN];
  logic [63:0]   m_mtime;
  logic [31:0]   m_shadow;
  logic          m_en;
  logic [7:0]    m_psc;
  int            m_edges;
  bit            chk_en = 1'b0;
  logic [HN-1:0] exp_tmr_d;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  function automatic void mdl_reset();
    m_msip = '0;
    for (int h = 0; h < HN; h++) m_cmp[h] = 64'hFFFF_FFFF_FFFF_FFFF;
    m_mtime = 64'd0; m_shadow = 32'd0; m_en = 1'b1; m_psc = 8'd0; m_edges = 0;
  endfunction

  function automatic void mdl_read(input logic [11:0] a, output logic [31:0] d, output logic e);
    int off = int'(a) & ~3;
    d = 32'd0; e = 1'b0;
    if (off < 'h40 && off / 4 < HN) d = {31'd0, m_msip[off/4]};
    else if (off >= 'h100 && off < 'h100 + 8 * HN)
      d = ((off - 'h100) % 8 == 4) ? m_cmp[(off - 'h100) / 8][63:32] : m_cmp[(off - 'h100) / 8][31:0];
    else if (off == 'h200) d = m_mtime[31:0];
    else if (off == 'h204) d = m_shadow;
    else if (off == 'h208) d = {16'd0, m_psc, 7'd0, m_en};
    else e = 1'b1;
  endfunction

  function automatic void mdl_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    int off = int'(a) & ~3;
    int h;
    logic [31:0] c;
    if (off < 'h40 && off / 4 < HN) begin
      if (s[0]) m_msip[off/4] = d[0];
    end else if (off >= 'h100 && off < 'h100 + 8 * HN) begin
      h = (off - 'h100) / 8;
      if ((off - 'h100) % 8 == 4) m_cmp[h][63:32] = merge(m_cmp[h][63:32], d, s);
      else m_cmp[h][31:0] = merge(m_cmp[h][31:0], d, s);
    end else if (off == 'h200) begin
      m_mtime[31:0] = merge(m_mtime[31:0], d, s);
    end else if (off == 'h204) begin
      m_mtime[63:32] = merge(m_mtime[63:32], d, s);
      m_shadow = m_mtime[63:32];
    end else if (off == 'h208) begin
      c = merge({16'd0, m_psc, 7'd0, m_en}, d, s);
      m_en = c[0]; m_psc = c[15:8]; m_edges = 0;
    end
  endfunction

  // One RTC rising edge: mtime advances on every (PSC+1)-th enabled edge
  function automatic void mdl_tick(input bit lost);
    if (m_en) begin
      m_edges++;
      if (m_edges == int'(m_psc) + 1) begin
        m_edges = 0;
        if (!lost) m_mtime = m_mtime + 64'd1;
      end
    end
  endfunction

  // Cycle compare: IRQ levels must follow the model state of the previous cycle
  always @(posedge clk) begin
    #2;
    if (!rst_n) begin
      exp_tmr_d = '0;
    end else begin
      if (chk_en) begin
        chk("tmr_irq", tmr_irq, exp_tmr_d);
        chk("sfr_irq", sfr_irq, m_msip);
      end
      for (int h = 0; h < HN; h++) exp_tmr_d[h] = (m_mtime >= m_cmp[h]);
    end
  end

  task automatic apb_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] ed;
    logic ee;
    @(negedge clk); paddr = a; pwrite = 1'b1; psel = 1'b1; penable = 1'b0; pwdata = d; pstrb = s;
    @(negedge clk); penable = 1'b1;
    #1;
    mdl_read(a, ed, ee);
    chk($sformatf("wr_slverr@%0h", a), pslverr, ee);
    if (ee) chk($sformatf("wr_err_prdata@%0h", a), prdata, 32'd0);
    mdl_write(a, d, s);
    @(negedge clk); psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic e);
    logic [31:0] ed;
    logic ee;
    @(negedge clk); paddr = a; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    @(negedge clk); penable = 1'b1;
    #1;
    d = prdata; e = pslverr;
    mdl_read(a, ed, ee);
    chk($sformatf("rd_data@%0h", a), prdata, ed);
    chk($sformatf("rd_slverr@%0h", a), pslverr, ee);
    if (!ee && ((int'(a) & ~3) == 'h200)) m_shadow = m_mtime[63:32];
    @(negedge clk); psel = 1'b0; penable = 1'b0;
    #1;
    chk("idle_prdata", prdata, 32'd0);
  endtask

  task automatic rtc_up();
    @(negedge clk); rtc = 1'b1;
    @(negedge clk);
    @(negedge clk); mdl_tick(1'b0);
  endtask

  task automatic rtc_down();
    @(negedge clk);
    @(negedge clk); rtc = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic rtc_tick();
    rtc_up();
    rtc_down();
  endtask

  task automatic read_all();
    logic [31:0] d;
    logic e;
    for (int i = 0; i < HN; i++) apb_read(12'(4 * i), d, e);
    for (int i = 0; i < 2 * HN; i++) apb_read(12'('h100 + 4 * i), d, e);
    apb_read(12'h200, d, e);
    apb_read(12'h204, d, e);
    apb_read(12'h208, d, e);
  endtask

  initial begin
    #500000;
    errors++; checks++;
    $display("FAIL watchdog: time limit expired");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    logic [31:0] d;
    logic e;
    int op;
    int h;
    rst_n = 1'b0; rtc = 1'b0; paddr = '0; psel = 1'b0; penable = 1'b0;
    pwrite = 1'b0; pwdata = '0; pstrb = '0;
    mdl_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    chk("rst_tmr", tmr_irq, 0);
    chk("rst_sfr", sfr_irq, 0);
    chk("rst_slverr", pslverr, 0);
    chk("rst_prdata", prdata, 0);
    chk("pready", pready, 1);
    read_all();
    apb_read(12'h208, d, e); chk("rst_ctrl", d, 32'h1);
    apb_read(12'h10C, d, e); chk("rst_cmp1h", d, 32'hFFFF_FFFF);
    apb_read(12'h200, d, e); chk("rst_mtimel", d, 32'h0);

    // Software interrupt
    apb_write(12'h008, 32'h1, 4'hF);
    chk("msip2_set", sfr_irq, 4'b0100);
    apb_read(12'h008, d, e); chk("msip2_read", d, 32'h1);
    apb_write(12'h008, 32'h0, 4'hF);
    chk("msip2_clr", sfr_irq, 4'b0000);

    // Prescaler and enable
    apb_write(12'h208, 32'h0000_0301, 4'hF);
    repeat (12) rtc_tick();
    apb_read(12'h200, d, e); chk("psc3_mtimel", d, 32'd3);
    apb_write(12'h208, 32'h0000_0300, 4'hF);
    repeat (5) rtc_tick();
    apb_read(12'h200, d, e); chk("en0_mtimel", d, 32'd3);
    apb_read(12'h208, d, e); chk("ctrl_rb", d, 32'h300);

    // Timer compare and IRQ latency
    apb_write(12'h208, 32'h1, 4'hF);
    apb_write(12'h200, 32'h0, 4'hF);
    apb_write(12'h204, 32'h0, 4'hF);
    apb_write(12'h104, 32'hFFFF_FFFF, 4'hF);
    apb_write(12'h100, 32'h10, 4'hF);
    apb_write(12'h104, 32'h0, 4'hF);
    apb_write(12'h10C, 32'hFFFF_FFFF, 4'hF);
    apb_write(12'h108, 32'h20, 4'hF);
    apb_write(12'h10C, 32'h0, 4'hF);
    repeat (15) rtc_tick();
    chk("irq_before_0x10", tmr_irq, 4'b0000);
    rtc_up();
    @(negedge clk); chk("irq_lat_pre", tmr_irq, 4'b0000);
    @(negedge clk); chk("irq_lat_post", tmr_irq, 4'b0001);
    rtc_down();
    apb_write(12'h100, 32'h100, 4'hF);
    chk("cmp_raise_pre", tmr_irq, 4'b0001);
    @(negedge clk); chk("cmp_raise_post", tmr_irq, 4'b0000);

    // Wrap and tear-free read
    apb_write(12'h200, 32'hFFFF_FFFF, 4'hF);
    apb_write(12'h204, 32'hFFFF_FFFF, 4'hF);
    rtc_tick();
    apb_read(12'h200, d, e); chk("wrap_l", d, 32'h0);
    apb_read(12'h204, d, e); chk("wrap_h", d, 32'h0);
    apb_write(12'h204, 32'h0, 4'hF);
    apb_write(12'h200, 32'hFFFF_FFFF, 4'hF);
    apb_read(12'h200, d, e); chk("tear_l", d, 32'hFFFF_FFFF);
    rtc_tick();
    apb_read(12'h204, d, e); chk("tear_h_shadow", d, 32'h0);
    apb_read(12'h200, d, e); chk("tear_l2", d, 32'h0);
    apb_read(12'h204, d, e); chk("tear_h2", d, 32'h1);

    // Unmapped accesses
    apb_write(12'h130, 32'hDEAD_BEEF, 4'hF);
    apb_write(12'h300, 32'hDEAD_BEEF, 4'hF);
    apb_write(12'h010, 32'h1, 4'hF);
    apb_read(12'h130, d, e); chk("unm130_err", e, 1); chk("unm130_data", d, 0);
    apb_read(12'h300, d, e); chk("unm300_err", e, 1); chk("unm300_data", d, 0);
    apb_read(12'h010, d, e); chk("unm010_err", e, 1);
    read_all();

    // MTIMEL write in the same cycle as an RTC rise
    @(negedge clk); rtc = 1'b1;
    @(negedge clk); paddr = 12'h200; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
    pwdata = 32'h55; pstrb = 4'hF;
    @(negedge clk); penable = 1'b1;
    #1;
    mdl_write(12'h200, 32'h55, 4'hF);
    mdl_tick(1'b1);
    @(negedge clk); psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    rtc_down();
    apb_read(12'h200, d, e); chk("wr_vs_tick", d, 32'h55);

    // Randomized traffic
    for (int it = 0; it < 400; it++) begin
      op = $urandom_range(0, 9);
      h = $urandom_range(0, HN);
      case (op)
        0: apb_write(12'(4 * h), $urandom, 4'($urandom));
        1, 2: begin
          if ($urandom_range(0, 1) == 1)
            apb_write(12'('h104 + 8 * h), ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'h0,
                      ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF);
          else
            apb_write(12'('h100 + 8 * h), 32'($urandom_range(0, 60)),
                      ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF);
        end
        3: apb_write(12'h200, 32'($urandom_range(0, 50)), 4'hF);
        4: apb_write(12'h204, ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'h0, 4'hF);
        5: apb_write(12'h208, {22'd0, 2'($urandom_range(0, 3)), 7'd0, 1'($urandom_range(0, 3) != 0)}, 4'hF);
        6, 7: rtc_tick();
        8: apb_read(12'($urandom), d, e);
        9: begin
          apb_read(12'h200 | 12'($urandom_range(0, 3)), d, e);
          apb_read(12'h204, d, e);
        end
        default: rtc_tick();
      endcase
    end
    read_all();

    // Asynchronous reset in mid-operation
    apb_write(12'h004, 32'h1, 4'hF);
    apb_write(12'h11C, 32'h0, 4'hF);
    apb_write(12'h118, 32'h0, 4'hF);
    @(negedge clk);
    chk("pre_rst_sfr1", sfr_irq[1], 1);
    chk("pre_rst_tmr3", tmr_irq[3], 1);
    #2;
    rst_n = 1'b0;
    mdl_reset();
    #1;
    chk("midrst_tmr", tmr_irq, 0);
    chk("midrst_sfr", sfr_irq, 0);
    @(negedge clk); rst_n = 1'b1;
    apb_read(12'h208, d, e); chk("postrst_ctrl", d, 32'h1);
    apb_read(12'h004, d, e); chk("postrst_msip1", d, 32'h0);
    apb_read(12'h118, d, e); chk("postrst_cmp3l", d, 32'hFFFF_FFFF);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
